// File: rtl/reg_file_pkg.sv
// Shared sizing and the write-port lookup used by both the read bypass and the
// scoreboard clear, so the two always agree on which port wins.
package reg_file_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_AW    = $clog2(RF_NREGS);

    // Fixed maxima let one non-parameterised function serve any instance size.
    localparam int MAX_NWR = 4;
    localparam int MAX_AW  = 8;
    localparam int MAX_IW  = $clog2(MAX_NWR);

    typedef struct packed {
        logic              hit;
        logic [MAX_IW-1:0] idx;
    } wr_sel_t;

    // Ascending scan: a later (higher-index) port overwrites an earlier hit.
    function automatic wr_sel_t wr_lookup(
        input logic [MAX_NWR-1:0]        wren,
        input logic [MAX_NWR*MAX_AW-1:0] addrs,
        input logic [MAX_AW-1:0]         a
    );
        wr_sel_t s;
        s = '0;
        for (int k = 0; k < MAX_NWR; k++) begin
            if (wren[k] && (a != '0) && (addrs[k*MAX_AW +: MAX_AW] == a)) begin
                s.hit = 1'b1;
                s.idx = MAX_IW'(k);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bundle for the multi-port register file.
interface reg_file_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
);
    logic [NWR-1:0]      rd_wren;
    logic [NWR*AW-1:0]   rd_addr;
    logic [NWR*XLEN-1:0] rd_data;
    logic [NRD*AW-1:0]   rs_addr;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_wren, rd_addr, rd_data, rs_addr, alloc_en, alloc_addr,
        input  rs_data, rs_busy, busy_vec
    );
    modport slave (
        input  rd_wren, rd_addr, rd_data, rs_addr, alloc_en, alloc_addr,
        output rs_data, rs_busy, busy_vec
    );
endinterface

// File: rtl/reg_read_port.sv
// One combinational read port: x0 forced to zero, same-cycle write bypass,
// and busy masked while the completing write is being forwarded.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic [AW-1:0]                  i_addr,
    input  logic [NREGS-1:0][XLEN-1:0]     i_regf,
    input  logic [MAX_NWR-1:0]             i_wren,
    input  logic [MAX_NWR*MAX_AW-1:0]      i_waddr,
    input  logic [MAX_NWR-1:0][XLEN-1:0]   i_wdata,
    input  logic [NREGS-1:0]               i_busy,
    output logic [XLEN-1:0]                o_data,
    output logic                           o_busy
);
    wr_sel_t w_sel;

    always_comb begin
        w_sel = wr_lookup(i_wren, i_waddr, MAX_AW'(i_addr));
        if (i_addr == '0) begin
            o_data = '0;
            o_busy = 1'b0;
        end else begin
            o_data = w_sel.hit ? i_wdata[w_sel.idx] : i_regf[i_addr];
            o_busy = i_busy[i_addr] & ~w_sel.hit;
        end
    end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-through bypass and a per-register
// busy scoreboard (set on alloc at decode, cleared on write at writeback).
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NWR-1:0]      i_rd_wren,
    input  logic [NWR*AW-1:0]   i_rd_addr,
    input  logic [NWR*XLEN-1:0] i_rd_data,
    input  logic [NRD*AW-1:0]   i_rs_addr,
    input  logic                i_alloc_en,
    input  logic [AW-1:0]       i_alloc_addr,
    output logic [NRD*XLEN-1:0] o_rs_data,
    output logic [NRD-1:0]      o_rs_busy,
    output logic [NREGS-1:0]    o_busy_vec
);
    logic [NREGS-1:0][XLEN-1:0]   r_regf;
    logic [NREGS-1:0]             r_busy;

    logic [MAX_NWR-1:0]           w_wren_pad;
    logic [MAX_NWR*MAX_AW-1:0]    w_addr_pad;
    logic [MAX_NWR-1:0][XLEN-1:0] w_data_pad;
    wr_sel_t                      w_wsel [NREGS];

    // Widen the write bundle to the package maxima; unused ports stay disabled.
    always_comb begin
        w_wren_pad = '0;
        w_addr_pad = '0;
        w_data_pad = '0;
        for (int k = 0; k < NWR; k++) begin
            w_wren_pad[k]                      = i_rd_wren[k];
            w_addr_pad[k*MAX_AW +: MAX_AW]     = MAX_AW'(i_rd_addr[k*AW +: AW]);
            w_data_pad[k]                      = i_rd_data[k*XLEN +: XLEN];
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++)
            w_wsel[r] = wr_lookup(w_wren_pad, w_addr_pad, MAX_AW'(r));
    end

    // Entry 0 is never touched after reset, so x0 and busy[0] stay zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_regf <= '0;
            r_busy <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (w_wsel[r].hit)
                    r_regf[r] <= w_data_pad[w_wsel[r].idx];
                // A newly issued producer supersedes the one completing now.
                if (i_alloc_en && (i_alloc_addr == AW'(r)))
                    r_busy[r] <= 1'b1;
                else if (w_wsel[r].hit)
                    r_busy[r] <= 1'b0;
            end
        end
    end

    assign o_busy_vec = r_busy;

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        reg_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rd (
            .i_addr  (i_rs_addr[j*AW +: AW]),
            .i_regf  (r_regf),
            .i_wren  (w_wren_pad),
            .i_waddr (w_addr_pad),
            .i_wdata (w_data_pad),
            .i_busy  (r_busy),
            .o_data  (o_rs_data[j*XLEN +: XLEN]),
            .o_busy  (o_rs_busy[j])
        );
    end
endmodule
